// File: rtl/pmem_arbiter_pkg.sv
// Shared types for the L1-to-physical-memory arbiter: line/address widths and the
// grant state encoding.
package pmem_arbiter_pkg;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 128;
  localparam int unsigned SEL_W  = 16;

  typedef logic [DATA_W-1:0] lc3b_line;
  typedef logic [ADDR_W-1:0] lc3b_line_addr;

  typedef enum logic [1:0] {
    IDLE,
    GNT_I,
    GNT_D,
    RELEASE
  } pmem_arb_state_t;

  typedef enum logic {
    LAST_I = 1'b0,
    LAST_D = 1'b1
  } gnt_src_t;

endpackage

// File: rtl/pmem_arbiter_if.sv
// Wishbone line-transfer bus: a cache master port or the physical memory port.
interface pmem_arbiter_if #(
  parameter int unsigned ADDR_W = pmem_arbiter_pkg::ADDR_W,
  parameter int unsigned DATA_W = pmem_arbiter_pkg::DATA_W,
  parameter int unsigned SEL_W  = pmem_arbiter_pkg::SEL_W
);

  logic              cyc;
  logic              stb;
  logic              we;
  logic [ADDR_W-1:0] adr;
  logic [SEL_W-1:0]  sel;
  logic [DATA_W-1:0] dat_m;
  logic              ack;
  logic [DATA_W-1:0] dat_s;

  modport master (
    output cyc, stb, we, adr, sel, dat_m,
    input  ack, dat_s
  );

  modport slave (
    input  cyc, stb, we, adr, sel, dat_m,
    output ack, dat_s
  );

endinterface

// File: rtl/pmem_arbiter.sv
// Two-master (I-cache, D-cache) to one-slave Wishbone arbiter with round-robin
// tie breaking and a one-cycle bus release after every completed line transfer.
module pmem_arbiter
  import pmem_arbiter_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  pmem_arbiter_if.slave  i,
  pmem_arbiter_if.slave  d,
  pmem_arbiter_if.master pm
);

  pmem_arb_state_t state_q, state_d;
  gnt_src_t        last_q, last_d;
  logic            i_req, d_req;

  assign i_req = i.cyc & i.stb;
  assign d_req = d.cyc & d.stb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= LAST_I;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        // On a tie the master that did not win last time is served.
        if (i_req && d_req)
          state_d = (last_q == LAST_I) ? GNT_D : GNT_I;
        else if (i_req)
          state_d = GNT_I;
        else if (d_req)
          state_d = GNT_D;
        if (state_d == GNT_I) last_d = LAST_I;
        if (state_d == GNT_D) last_d = LAST_D;
      end
      GNT_I, GNT_D: begin
        if (pm.ack) state_d = RELEASE;
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pm.cyc   = 1'b0;
    pm.stb   = 1'b0;
    pm.we    = 1'b0;
    pm.adr   = '0;
    pm.sel   = '0;
    pm.dat_m = '0;
    i.ack    = 1'b0;
    d.ack    = 1'b0;
    unique case (state_q)
      GNT_I: begin
        pm.cyc   = i.cyc;
        pm.stb   = i.stb;
        pm.we    = i.we;
        pm.adr   = i.adr;
        pm.sel   = i.sel;
        pm.dat_m = i.dat_m;
        i.ack    = pm.ack;
      end
      GNT_D: begin
        pm.cyc   = d.cyc;
        pm.stb   = d.stb;
        pm.we    = d.we;
        pm.adr   = d.adr;
        pm.sel   = d.sel;
        pm.dat_m = d.dat_m;
        d.ack    = pm.ack;
      end
      default: ;
    endcase
  end

  // Read data is broadcast; only the ack tells a cache the line is its own.
  assign i.dat_s = pm.dat_s;
  assign d.dat_s = pm.dat_s;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Self-checking bench for pmem_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a bus-ownership model.
module tb_pmem_arbiter;
  import pmem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEL_W(SEL_W)) i_bus ();
  pmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEL_W(SEL_W)) d_bus ();
  pmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEL_W(SEL_W)) pm_bus ();

  pmem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .i   (i_bus),
    .d   (d_bus),
    .pm  (pm_bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: who owns the memory bus (0 nobody, 1 I-cache, 2 D-cache), whether the
  // bus is in its post-transfer quiet cycle, and who won the previous grant.
  int   m_owner  = 0;
  bit   m_quiet  = 1'b0;
  bit   m_last_d = 1'b0;
  logic e_i_ack, e_d_ack;

  localparam logic [127:0] LINE1 = 128'hDEAD_0000_0000_0000_0000_0000_0000_BEEF;
  localparam logic [127:0] LINE3 = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_owner  = 0;
    m_quiet  = 1'b0;
    m_last_d = 1'b0;
  endtask

  task automatic check_cycle();
    logic              e_cyc, e_stb, e_we;
    logic [ADDR_W-1:0] e_adr;
    logic [SEL_W-1:0]  e_sel;
    logic [DATA_W-1:0] e_dat;
    #1;
    {e_cyc, e_stb, e_we, e_adr, e_sel, e_dat} = '0;
    e_i_ack = 1'b0;
    e_d_ack = 1'b0;
    if (m_owner == 1) begin
      {e_cyc, e_stb, e_we} = {i_bus.cyc, i_bus.stb, i_bus.we};
      {e_adr, e_sel, e_dat} = {i_bus.adr, i_bus.sel, i_bus.dat_m};
      e_i_ack = pm_bus.ack;
    end else if (m_owner == 2) begin
      {e_cyc, e_stb, e_we} = {d_bus.cyc, d_bus.stb, d_bus.we};
      {e_adr, e_sel, e_dat} = {d_bus.adr, d_bus.sel, d_bus.dat_m};
      e_d_ack = pm_bus.ack;
    end
    chk("pm_cyc", pm_bus.cyc, e_cyc);
    chk("pm_stb", pm_bus.stb, e_stb);
    chk("pm_we", pm_bus.we, e_we);
    chk("pm_adr", pm_bus.adr, e_adr);
    chk("pm_sel", pm_bus.sel, e_sel);
    chk("pm_dat_m", pm_bus.dat_m, e_dat);
    chk("i_ack", i_bus.ack, e_i_ack);
    chk("d_ack", d_bus.ack, e_d_ack);
    chk("i_dat_s", i_bus.dat_s, pm_bus.dat_s);
    chk("d_dat_s", d_bus.dat_s, pm_bus.dat_s);
  endtask

  task automatic advance();
    bit ir, dr;
    ir = i_bus.cyc & i_bus.stb;
    dr = d_bus.cyc & d_bus.stb;
    if (m_owner != 0) begin
      if (pm_bus.ack) begin
        m_owner = 0;
        m_quiet = 1'b1;
      end
    end else if (m_quiet) begin
      m_quiet = 1'b0;
    end else if (ir || dr) begin
      if (ir && dr) m_owner = m_last_d ? 1 : 2;
      else          m_owner = ir ? 1 : 2;
      m_last_d = (m_owner == 2);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drop_all();
    {i_bus.cyc, i_bus.stb, i_bus.we} = '0;
    {d_bus.cyc, d_bus.stb, d_bus.we} = '0;
    pm_bus.ack = 1'b0;
  endtask

  task automatic do_reset();
    drop_all();
    rst = 1'b1;
    #1;
    model_reset();
    check_cycle();
    chk("rst_pm_cyc", pm_bus.cyc, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int   seq[$];
    bit   d_off;
    bit   act[2];
    int   gap[2];
    logic glitch;

    i_bus.adr = '0; i_bus.sel = '0; i_bus.dat_m = '0;
    d_bus.adr = '0; d_bus.sel = '0; d_bus.dat_m = '0;
    pm_bus.dat_s = '0;
    do_reset();

    // I-cache read, memory acks on cycle 4.
    i_bus.cyc = 1; i_bus.stb = 1; i_bus.we = 0; i_bus.adr = 12'h0A3; i_bus.sel = 16'hFFFF;
    check_cycle();
    chk("t1_c0_cyc", pm_bus.cyc, 0);
    advance();
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) begin pm_bus.ack = 1; pm_bus.dat_s = LINE1; end
      check_cycle();
      chk("t1_adr", pm_bus.adr, 12'h0A3);
      chk("t1_cyc", pm_bus.cyc, 1);
      chk("t1_iack", i_bus.ack, (c == 4));
      chk("t1_dack", d_bus.ack, 0);
      if (c == 4) chk("t1_idat", i_bus.dat_s, LINE1);
      advance();
    end
    drop_all();
    check_cycle();
    chk("t1_release_cyc", pm_bus.cyc, 0);
    advance();

    // Simultaneous requests after reset: D first, then I, then D again.
    do_reset();
    i_bus.cyc = 1; i_bus.stb = 1; i_bus.adr = 12'h111;
    d_bus.cyc = 1; d_bus.stb = 1; d_bus.adr = 12'h222;
    check_cycle(); advance();
    pm_bus.ack = 1;
    check_cycle();
    chk("t2_first_d_adr", pm_bus.adr, 12'h222);
    chk("t2_first_dack", d_bus.ack, 1);
    chk("t2_first_iack", i_bus.ack, 0);
    advance();
    pm_bus.ack = 0; d_bus.cyc = 0; d_bus.stb = 0;
    check_cycle(); chk("t2_release", pm_bus.cyc, 0); advance();
    check_cycle(); chk("t2_idle", pm_bus.cyc, 0); advance();
    pm_bus.ack = 1;
    check_cycle();
    chk("t2_second_i_adr", pm_bus.adr, 12'h111);
    chk("t2_second_iack", i_bus.ack, 1);
    advance();
    pm_bus.ack = 0; d_bus.cyc = 1; d_bus.stb = 1;
    check_cycle(); advance();
    check_cycle(); advance();
    check_cycle();
    chk("t2_third_d_adr", pm_bus.adr, 12'h222);
    pm_bus.ack = 1;
    check_cycle(); advance();
    drop_all();
    check_cycle(); advance();
    check_cycle(); advance();

    // D-cache write-back passes we/sel/data through untouched.
    d_bus.cyc = 1; d_bus.stb = 1; d_bus.we = 1; d_bus.adr = 12'h3C5;
    d_bus.sel = 16'hFFFF; d_bus.dat_m = LINE3;
    check_cycle(); advance();
    check_cycle();
    chk("t3_we", pm_bus.we, 1);
    chk("t3_dat_m", pm_bus.dat_m, LINE3);
    chk("t3_sel", pm_bus.sel, 16'hFFFF);
    advance();
    pm_bus.ack = 1;
    check_cycle();
    chk("t3_dack", d_bus.ack, 1);
    chk("t3_iack", i_bus.ack, 0);
    advance();
    drop_all();
    check_cycle(); advance();
    check_cycle(); advance();

    // I requests continuously, D re-requests after every ack: grants alternate.
    d_off = 0;
    d_bus.we = 0;
    for (int c = 0; c < 40 && seq.size() < 4; c++) begin
      i_bus.cyc = 1; i_bus.stb = 1; i_bus.adr = 12'h400;
      d_bus.cyc = !d_off; d_bus.stb = !d_off;
      pm_bus.ack = (m_owner != 0);
      check_cycle();
      if (i_bus.ack) seq.push_back(1);
      if (d_bus.ack) seq.push_back(2);
      d_off = e_d_ack;
      advance();
    end
    chk("t4_grants", seq.size(), 4);
    for (int k = 0; k < 4; k++)
      chk("t4_order", (k < seq.size()) ? seq[k] : 0, (k % 2 == 0) ? 1 : 2);
    drop_all();
    check_cycle(); advance();
    check_cycle(); advance();

    // Reset in the middle of a D grant, late ack ignored, next tie back to D.
    do_reset();
    i_bus.cyc = 1; i_bus.stb = 1; i_bus.adr = 12'h555;
    d_bus.cyc = 1; d_bus.stb = 1; d_bus.adr = 12'h666;
    check_cycle(); advance();
    check_cycle();
    chk("t5_granted_d", pm_bus.adr, 12'h666);
    rst = 1;
    #1;
    chk("t5_rst_cyc", pm_bus.cyc, 0);
    chk("t5_rst_stb", pm_bus.stb, 0);
    pm_bus.ack = 1;
    #1;
    chk("t5_late_dack", d_bus.ack, 0);
    chk("t5_late_iack", i_bus.ack, 0);
    model_reset();
    rst = 0;
    check_cycle();
    advance();
    pm_bus.ack = 0;
    check_cycle();
    chk("t5_next_tie_d", pm_bus.adr, 12'h666);
    pm_bus.ack = 1;
    check_cycle(); advance();
    drop_all();
    check_cycle(); advance();
    check_cycle(); advance();

    // Spurious ack while idle is dropped and leaves the arbiter idle.
    pm_bus.ack = 1;
    check_cycle();
    chk("t6_iack", i_bus.ack, 0);
    chk("t6_dack", d_bus.ack, 0);
    advance();
    pm_bus.ack = 0; i_bus.cyc = 1; i_bus.stb = 1; i_bus.adr = 12'h777;
    check_cycle(); advance();
    check_cycle();
    chk("t6_then_grant", pm_bus.cyc, 1);
    pm_bus.ack = 1;
    check_cycle(); advance();
    drop_all();
    check_cycle(); advance();

    // Randomized traffic.
    act[0] = 0; act[1] = 0; gap[0] = 0; gap[1] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int m = 0; m < 2; m++) begin
        if (!act[m]) begin
          if (gap[m] > 0) gap[m]--;
          else if ($urandom % 4 == 0) begin
            act[m] = 1;
            if (m == 0) begin
              i_bus.we = 1'($urandom); i_bus.adr = ADDR_W'($urandom);
              i_bus.sel = SEL_W'($urandom);
              i_bus.dat_m = {$urandom, $urandom, $urandom, $urandom};
            end else begin
              d_bus.we = 1'($urandom); d_bus.adr = ADDR_W'($urandom);
              d_bus.sel = SEL_W'($urandom);
              d_bus.dat_m = {$urandom, $urandom, $urandom, $urandom};
            end
          end
        end
      end
      glitch = ($urandom % 20 == 0);
      i_bus.cyc = act[0] & !glitch; i_bus.stb = act[0] & ($urandom % 16 != 0);
      glitch = ($urandom % 20 == 0);
      d_bus.cyc = act[1] & !glitch; d_bus.stb = act[1] & ($urandom % 16 != 0);
      pm_bus.ack = (m_owner != 0) ? ($urandom % 3 == 0) : ($urandom % 8 == 0);
      pm_bus.dat_s = {$urandom, $urandom, $urandom, $urandom};
      check_cycle();
      if (act[0] && e_i_ack) begin act[0] = 0; gap[0] = $urandom % 4; end
      if (act[1] && e_d_ack) begin act[1] = 0; gap[1] = $urandom % 4; end
      if ($urandom % 400 == 0) begin
        rst = 1;
        #1;
        model_reset();
        check_cycle();
        rst = 0;
      end
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
